wb_arbiter2: RTL and testbench

//  Two-master, one-slave Wishbone arbiter: shares a single slave port (e.g. the J1 data bus to
//  the peripheral fabric) between masters m0 and m1. Round-robin grant, held for the whole
//  bus cycle (CYC). Includes a per-transfer watchdog that completes a stuck transfer with a fault word.

---
 rtl/wb_arbiter2_if.sv | 16 +
 rtl/wb_arbiter2.sv | 64 ++++++
 tb/tb_wb_arbiter2.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter2_if.sv
// wb_arbiter2_if: classic Wishbone point-to-point bundle with master/slave views
interface wb_arbiter2_if #(
    parameter int ADR_WIDTH = 16,
    parameter int DAT_WIDTH = 16
);
    logic [ADR_WIDTH-1:0] adr;
    logic [DAT_WIDTH-1:0] dat_w;
    logic [DAT_WIDTH-1:0] dat_r;
    logic                 we;
    logic                 cyc;
    logic                 stb;
    logic                 ack;

    modport master (output adr, dat_w, we, cyc, stb, input dat_r, ack);
    modport slave  (input adr, dat_w, we, cyc, stb, output dat_r, ack);
endinterface

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master round-robin Wishbone arbiter with per-transfer watchdog
module wb_arbiter2 #(
    parameter int ADR_WIDTH = 16,
    parameter int DAT_WIDTH = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    wb_arbiter2_if.slave        m0,
    wb_arbiter2_if.slave        m1,
    wb_arbiter2_if.master       s,
    output logic [1:0]          gnt_o,
    output logic                timeout_o
);
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, G0, G1} state_t;

    state_t               state, state_n;
    logic                 last;
    logic [WDW-1:0]       wd;
    logic                 act, sel1, gstb, wd_fire;
    logic [DAT_WIDTH-1:0] rdata;

    // state register, round-robin history (master that last owned the bus) and watchdog count
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
            wd    <= '0;
        end else begin
            state <= state_n;
            if (state == G0 && !m0.cyc)
                last <= 1'b0;
            else if (state == G1 && !m1.cyc)
                last <= 1'b1;
            wd <= (!act || s.ack || !gstb || wd_fire) ? '0 : wd + WDW'(1);
        end
    end

    // next-state selection and combinational bus steering toward the granted master
    always_comb begin
        act       = state != IDLE;
        sel1      = state == G1;
        gstb      = act && (sel1 ? m1.stb : m0.stb);
        wd_fire   = gstb && wd == WDW'(TIMEOUT);
        timeout_o = wd_fire && !s.ack;
        rdata     = timeout_o ? {DAT_WIDTH{1'b1}} : s.dat_r;
        state_n   = state == IDLE ? ((m0.cyc && m1.cyc) ? (last ? G0 : G1) :
                                     m0.cyc ? G0 : m1.cyc ? G1 : IDLE) :
                    state == G0   ? (m0.cyc ? G0 : IDLE) :
                    state == G1   ? (m1.cyc ? G1 : IDLE) : IDLE;
        s.cyc     = act;
        s.stb     = gstb && !wd_fire;
        s.we      = act && (sel1 ? m1.we : m0.we);
        s.adr     = !act ? {ADR_WIDTH{1'b0}} : sel1 ? m1.adr : m0.adr;
        s.dat_w   = !act ? {DAT_WIDTH{1'b0}} : sel1 ? m1.dat_w : m0.dat_w;
        m0.ack    = state == G0 && (s.ack || wd_fire);
        m1.ack    = sel1 && (s.ack || wd_fire);
        m0.dat_r  = state == G0 ? rdata : '0;
        m1.dat_r  = sel1 ? rdata : '0;
        gnt_o     = {sel1, state == G0};
    end
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed scenarios plus randomized traffic against a bus-ownership model
module tb_wb_arbiter2;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] gnt;
    logic       tmo;
    int         vectors = 0;
    int         miscompares = 0;

    wb_arbiter2_if m0_bus ();
    wb_arbiter2_if m1_bus ();
    wb_arbiter2_if s_bus ();

    wb_arbiter2 #(.ADR_WIDTH(16), .DAT_WIDTH(16), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst), .m0(m0_bus), .m1(m1_bus), .s(s_bus),
        .gnt_o(gnt), .timeout_o(tmo)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout bench did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic drive(input int k, input logic cyc, stb, we, input logic [15:0] adr, dat);
        if (k == 0) begin
            m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we; m0_bus.adr = adr; m0_bus.dat_w = dat;
        end else begin
            m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we; m1_bus.adr = adr; m1_bus.dat_w = dat;
        end
    endtask

    task automatic idle_all;
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        drive(1, 0, 0, 0, 16'h0, 16'h0);
        s_bus.ack = 0;
        s_bus.dat_r = 16'h0;
    endtask

    task automatic do_reset;
        rst = 1;
        idle_all();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        drive(0, 1, 1, 1, 16'h1234, 16'h5678);
        s_bus.ack = 1;
        s_bus.dat_r = 16'hAAAA;
        tick();
        tick();
        settle();
        vectors++;
        if ({gnt, s_bus.cyc, s_bus.stb, s_bus.we, m0_bus.ack, m1_bus.ack, tmo} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 00000000", {gnt, s_bus.cyc, s_bus.stb, s_bus.we, m0_bus.ack, m1_bus.ack, tmo});
        end
        vectors++;
        if ({s_bus.adr, s_bus.dat_w, m0_bus.dat_r} !== 48'h0) begin
            miscompares++;
            $display("FAIL reset_data got %h want 0", {s_bus.adr, s_bus.dat_w, m0_bus.dat_r});
        end
        idle_all();
        rst = 0;
        tick();
    endtask

    task automatic test_write;
        do_reset();
        drive(0, 1, 1, 1, 16'h0010, 16'hBEEF);
        settle();
        vectors++;
        if ({gnt, s_bus.cyc} !== 3'b000) begin
            miscompares++;
            $display("FAIL wr_latency got %b want 000", {gnt, s_bus.cyc});
        end
        tick();
        settle();
        vectors++;
        if ({gnt, s_bus.cyc, s_bus.stb, s_bus.we, m0_bus.ack} !== 6'b011110) begin
            miscompares++;
            $display("FAIL wr_grant got %b want 011110", {gnt, s_bus.cyc, s_bus.stb, s_bus.we, m0_bus.ack});
        end
        vectors++;
        if ({s_bus.adr, s_bus.dat_w} !== {16'h0010, 16'hBEEF}) begin
            miscompares++;
            $display("FAIL wr_mux got %h want 0010beef", {s_bus.adr, s_bus.dat_w});
        end
        tick();
        settle();
        vectors++;
        if (m0_bus.ack !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_early_ack got %b want 0", m0_bus.ack);
        end
        tick();
        s_bus.ack = 1;
        settle();
        vectors++;
        if ({m0_bus.ack, m1_bus.ack, tmo} !== 3'b100) begin
            miscompares++;
            $display("FAIL wr_ack got %b want 100", {m0_bus.ack, m1_bus.ack, tmo});
        end
        tick();
        s_bus.ack = 0;
        drive(0, 0, 0, 0, 16'h0, 16'h0);
        settle();
        vectors++;
        if ({gnt, m0_bus.ack} !== 3'b010) begin
            miscompares++;
            $display("FAIL wr_release got %b want 010", {gnt, m0_bus.ack});
        end
        tick();
        settle();
        vectors++;
        if ({gnt, s_bus.cyc} !== 3'b000) begin
            miscompares++;
            $display("FAIL wr_idle got %b want 000", {gnt, s_bus.cyc});
        end
    endtask

    task automatic test_tie;
        logic [1:0] want [5] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
        do_reset();
        drive(0, 1, 0, 0, 16'h0, 16'h0);
        drive(1, 1, 0, 0, 16'h0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) drive(0, 0, 0, 0, 16'h0, 16'h0);
            settle();
            vectors++;
            if (gnt !== want[i]) begin
                miscompares++;
                $display("FAIL tie_gnt[%0d] got %b want %b", i, gnt, want[i]);
            end
            tick();
        end
        idle_all();
        tick();
        tick();
    endtask

    task automatic test_alternate;
        logic [1:0] exp_g = 2'b01;
        logic [1:0] prev = 2'b00;
        logic       d0 = 0, d1 = 0;
        int         grants = 0;
        do_reset();
        s_bus.ack = 1;
        drive(0, 1, 1, 0, 16'h0, 16'h0);
        drive(1, 1, 1, 0, 16'h0, 16'h0);
        for (int i = 0; i < 60 && grants < 6; i++) begin
            settle();
            if (gnt != 2'b00 && prev == 2'b00) begin
                vectors++;
                if (gnt !== exp_g) begin
                    miscompares++;
                    $display("FAIL alt_gnt[%0d] got %b want %b", grants, gnt, exp_g);
                end
                exp_g = ~exp_g;
                grants++;
            end
            d0 = gnt[0] & m0_bus.ack & m0_bus.cyc;
            d1 = gnt[1] & m1_bus.ack & m1_bus.cyc;
            prev = gnt;
            tick();
            drive(0, !d0, !d0, 0, 16'(i), 16'h0);
            drive(1, !d1, !d1, 0, 16'(i), 16'h0);
        end
        vectors++;
        if (grants < 6) begin
            miscompares++;
            $display("FAIL alt_count got %0d want 6", grants);
        end
        idle_all();
        tick();
        tick();
    endtask

    task automatic test_hold;
        do_reset();
        drive(1, 1, 1, 0, 16'h0200, 16'h0);
        tick();
        drive(0, 1, 1, 0, 16'h0100, 16'h0);
        for (int i = 0; i < 4; i++) begin
            s_bus.ack = 1;
            s_bus.dat_r = 16'h1000 + 16'(i);
            settle();
            vectors++;
            if ({gnt, m1_bus.ack, m0_bus.ack, m1_bus.dat_r, m0_bus.dat_r} !== {2'b10, 2'b10, 16'h1000 + 16'(i), 16'h0}) begin
                miscompares++;
                $display("FAIL hold_rd[%0d] got %h want %h", i, {gnt, m1_bus.ack, m0_bus.ack, m1_bus.dat_r, m0_bus.dat_r},
                         {2'b10, 2'b10, 16'h1000 + 16'(i), 16'h0});
            end
            tick();
        end
        s_bus.ack = 0;
        drive(1, 0, 0, 0, 16'h0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            settle();
            vectors++;
            if (gnt !== (i == 0 ? 2'b10 : i == 1 ? 2'b00 : 2'b01)) begin
                miscompares++;
                $display("FAIL hold_handoff[%0d] got %b", i, gnt);
            end
            tick();
        end
        idle_all();
        tick();
        tick();
    endtask

    task automatic test_timeout;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            drive(0, 1, 1, 0, 16'h0040, 16'h0);
            tick();
            for (int i = 1; i <= TO; i++) begin
                settle();
                vectors++;
                if ({s_bus.stb, m0_bus.ack, tmo} !== 3'b100) begin
                    miscompares++;
                    $display("FAIL wd_wait[%0d] got %b want 100", i, {s_bus.stb, m0_bus.ack, tmo});
                end
                tick();
            end
            if (pass == 1) begin
                s_bus.ack = 1;
                s_bus.dat_r = 16'h1234;
            end
            settle();
            vectors++;
            if (pass == 0 && {s_bus.stb, m0_bus.ack, tmo, m1_bus.ack, m0_bus.dat_r} !== {4'b0110, 16'hFFFF}) begin
                miscompares++;
                $display("FAIL wd_fire got %h want 6ffff", {s_bus.stb, m0_bus.ack, tmo, m1_bus.ack, m0_bus.dat_r});
            end
            if (pass == 1 && {m0_bus.ack, tmo, m0_bus.dat_r} !== {2'b10, 16'h1234}) begin
                miscompares++;
                $display("FAIL wd_ack_wins got %h want 21234", {m0_bus.ack, tmo, m0_bus.dat_r});
            end
            tick();
            s_bus.ack = 0;
            drive(0, 0, 0, 0, 16'h0, 16'h0);
            settle();
            vectors++;
            if (tmo !== 1'b0) begin
                miscompares++;
                $display("FAIL wd_pulse got %b want 0", tmo);
            end
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        drive(1, 1, 1, 1, 16'h0300, 16'h5555);
        tick();
        tick();
        rst = 1;
        settle();
        vectors++;
        if ({gnt, s_bus.stb} !== 3'b101) begin
            miscompares++;
            $display("FAIL rstmid_before got %b want 101", {gnt, s_bus.stb});
        end
        tick();
        rst = 0;
        drive(1, 0, 0, 0, 16'h0, 16'h0);
        s_bus.ack = 1;
        settle();
        vectors++;
        if ({gnt, s_bus.cyc, s_bus.stb, m1_bus.ack, tmo} !== 6'b0) begin
            miscompares++;
            $display("FAIL rstmid_after got %b want 000000", {gnt, s_bus.cyc, s_bus.stb, m1_bus.ack, tmo});
        end
        tick();
        idle_all();
    endtask

    task automatic test_random;
        int          owner = 0, last = 1, wd = 0, k, ackp;
        logic        c [2] = '{1'b0, 1'b0};
        logic        st [2], w [2];
        logic [15:0] a [2], d [2];
        logic        r, sack, gstb, raw, e_to;
        logic [15:0] sdat;
        logic [1:0]  e_gnt;
        logic [2:0]  e_ctl;
        logic [15:0] e_adr, e_dw;
        logic        e_ack [2];
        logic [15:0] e_dat [2];
        do_reset();
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99) < 2;
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(0, 7) == 0) c[m] = !c[m];
                st[m] = c[m] && $urandom_range(0, 9) != 0;
                w[m] = 1'($urandom);
                a[m] = 16'($urandom);
                d[m] = 16'($urandom);
                drive(m, c[m], st[m], w[m], a[m], d[m]);
            end
            ackp = ((n / 150) % 2) ? 6 : 45;
            sack = $urandom_range(0, 99) < ackp;
            sdat = 16'($urandom);
            rst = r;
            s_bus.ack = sack;
            s_bus.dat_r = sdat;
            settle();
            k = owner - 1;
            e_gnt = owner == 1 ? 2'b01 : owner == 2 ? 2'b10 : 2'b00;
            e_ack = '{1'b0, 1'b0};
            e_dat = '{16'h0, 16'h0};
            gstb = owner != 0 && st[owner == 2];
            raw = gstb && wd == TO;
            e_to = raw && !sack;
            e_ctl = 3'b000;
            e_adr = 16'h0;
            e_dw = 16'h0;
            if (owner != 0) begin
                e_ctl = {1'b1, gstb && !raw, w[k]};
                e_adr = a[k];
                e_dw = d[k];
                e_ack[k] = sack || raw;
                e_dat[k] = e_to ? 16'hFFFF : sdat;
            end
            vectors++;
            if ({gnt, tmo} !== {e_gnt, e_to}) begin
                miscompares++;
                $display("FAIL rnd_gnt[%0d] got %b want %b", n, {gnt, tmo}, {e_gnt, e_to});
            end
            vectors++;
            if ({s_bus.cyc, s_bus.stb, s_bus.we, s_bus.adr, s_bus.dat_w} !== {e_ctl, e_adr, e_dw}) begin
                miscompares++;
                $display("FAIL rnd_slave[%0d] got %h want %h", n, {s_bus.cyc, s_bus.stb, s_bus.we, s_bus.adr, s_bus.dat_w},
                         {e_ctl, e_adr, e_dw});
            end
            vectors++;
            if ({m0_bus.ack, m1_bus.ack, m0_bus.dat_r, m1_bus.dat_r} !== {e_ack[0], e_ack[1], e_dat[0], e_dat[1]}) begin
                miscompares++;
                $display("FAIL rnd_master[%0d] got %h want %h", n, {m0_bus.ack, m1_bus.ack, m0_bus.dat_r, m1_bus.dat_r},
                         {e_ack[0], e_ack[1], e_dat[0], e_dat[1]});
            end
            if (r) begin
                owner = 0;
                last = 1;
                wd = 0;
            end else if (owner == 0) begin
                owner = (c[0] && c[1]) ? (last == 0 ? 2 : 1) : c[0] ? 1 : c[1] ? 2 : 0;
                wd = 0;
            end else begin
                wd = (sack || !gstb || raw) ? 0 : wd + 1;
                if (!c[k]) begin
                    last = k;
                    owner = 0;
                end
            end
            tick();
        end
        rst = 0;
        idle_all();
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_tie();
        test_alternate();
        test_hold();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
